// File: rtl/bpred_pkg.sv
// Shared types for the PHT arbiter: 2-bit counter encoding, FSM states and
// the saturating counter update.
package bpred_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } upd_state_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'b01;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Synchronous FIFO of pending {index, outcome} counter updates.
// A push while full is accepted only when a pop happens in the same cycle.
module bpred_upd_fifo #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     push,
    input  logic [IDX_W-1:0]         push_index,
    input  logic                     push_outcome,
    input  logic                     pop,
    output logic [IDX_W-1:0]         head_index,
    output logic                     head_outcome,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign head_index   = mem[rd_ptr][IDX_W:1];
    assign head_outcome = mem[rd_ptr][0];

    always_ff @(posedge i_Clk) begin
        if (push_ok) mem[wr_ptr] <= {push_index, push_outcome};
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bpred_pht_arbiter.sv
// Single-port PHT arbiter: table init, DEC lookups and queued EX-stage
// read-modify-write counter updates with starvation protection.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  INIT    | writing INIT_CTR to one PHT entry per cycle, lookups stalled
//  IDLE    | no update in flight, port free for lookups
//  RD      | waiting for a port slot to read the FIFO head counter
//  WR      | holding the read counter, waiting to write the updated value
module bpred_pht_arbiter
    import bpred_pkg::*;
#(
    parameter int   BPRED_WIDTH  = 4,
    parameter int   UPD_DEPTH    = 4,
    parameter int   STARVE_LIMIT = 8,
    parameter ctr_t INIT_CTR     = 2'b10
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_DEC_Is_Branch,
    input  logic [BPRED_WIDTH-1:0] i_DEC_Index,
    output logic                   o_Lookup_Stall,
    output logic                   o_Pred_Valid,
    output logic                   o_Prediction,
    input  logic                   i_ALU_Branch_Valid,
    input  logic                   i_ALU_Branch_Outcome,
    input  logic [BPRED_WIDTH-1:0] i_ALU_Index,
    output logic                   o_Upd_Drop,
    output logic                   o_Init_Done,
    output logic [BPRED_WIDTH-1:0] o_PHT_Addr,
    output logic                   o_PHT_We,
    output logic [1:0]             o_PHT_Wdata,
    input  logic [1:0]             i_PHT_Rdata
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W    = $clog2(UPD_DEPTH) + 1;
    localparam logic [BPRED_WIDTH-1:0] LAST_IDX = '1;

    upd_state_t             state_q, state_d;
    logic [BPRED_WIDTH-1:0] init_idx_q;
    logic                   init_done_q;
    logic [STARVE_W-1:0]    starve_q;
    ctr_t                   held_q;
    logic                   wr_entry_q;
    logic                   pred_valid_q;
    logic                   drop_q;

    logic [BPRED_WIDTH-1:0] head_index;
    logic                   head_outcome;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    logic                   in_rdwr;
    logic                   starved;
    logic                   lookup_stall;
    logic                   lookup_grant;
    logic                   upd_grant;
    logic                   push;
    logic                   pop;
    ctr_t                   wr_base;
    ctr_t                   wr_ctr;
    logic [BPRED_WIDTH-1:0] addr_c;
    logic                   we_c;
    ctr_t                   wdata_c;

    bpred_upd_fifo #(
        .IDX_W (BPRED_WIDTH),
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .push         (push),
        .push_index   (i_ALU_Index),
        .push_outcome (i_ALU_Branch_Outcome),
        .pop          (pop),
        .head_index   (head_index),
        .head_outcome (head_outcome),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    assign push         = i_ALU_Branch_Valid;
    assign in_rdwr      = (state_q == ST_RD) || (state_q == ST_WR);
    assign starved      = in_rdwr && (starve_q == STARVE_W'(STARVE_LIMIT));
    assign lookup_stall = (state_q == ST_INIT) || starved;
    assign lookup_grant = i_DEC_Is_Branch && !lookup_stall;
    assign upd_grant    = in_rdwr && !lookup_grant;
    assign pop          = (state_q == ST_WR) && upd_grant;

    // The read data is only on the bus in the WR entry cycle; later WR cycles use the held copy.
    assign wr_base = wr_entry_q ? i_PHT_Rdata : held_q;
    assign wr_ctr  = sat_update(wr_base, head_outcome);

    always_comb begin
        state_d = state_q;
        addr_c  = i_DEC_Index;
        we_c    = 1'b0;
        wdata_c = wr_ctr;
        case (state_q)
            ST_INIT: begin
                addr_c  = init_idx_q;
                we_c    = 1'b1;
                wdata_c = INIT_CTR;
                if (init_idx_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_RD;
            end
            ST_RD: begin
                if (upd_grant) begin
                    addr_c  = head_index;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (upd_grant) begin
                    addr_c  = head_index;
                    we_c    = 1'b1;
                    state_d = ((fifo_count > CNT_W'(1)) || push) ? ST_RD : ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            init_done_q  <= 1'b0;
            starve_q     <= '0;
            held_q       <= CTR_SNT;
            wr_entry_q   <= 1'b0;
            pred_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_entry_q   <= (state_q == ST_RD) && upd_grant;
            pred_valid_q <= lookup_grant;
            drop_q       <= push && fifo_full && !pop;
            if (state_q == ST_INIT) init_idx_q <= init_idx_q + BPRED_WIDTH'(1);
            if ((state_q == ST_INIT) && (state_d == ST_IDLE)) init_done_q <= 1'b1;
            if (wr_entry_q) held_q <= i_PHT_Rdata;
            if (upd_grant) begin
                starve_q <= '0;
            end else if (in_rdwr && lookup_grant && !starved) begin
                starve_q <= starve_q + STARVE_W'(1);
            end
        end
    end

    assign o_Lookup_Stall = lookup_stall;
    assign o_Pred_Valid   = pred_valid_q;
    assign o_Prediction   = pred_valid_q & i_PHT_Rdata[1];
    assign o_Upd_Drop     = drop_q;
    assign o_Init_Done    = init_done_q;
    assign o_PHT_Addr     = addr_c;
    assign o_PHT_We       = we_c & i_Reset;
    assign o_PHT_Wdata    = wdata_c;

endmodule

// File: tb/tb_bpred_pht_arbiter.sv
// Directed bench for bpred_pht_arbiter with a behavioural single-port PHT.
module tb_bpred_pht_arbiter;

    logic       clk;
    logic       rst_n;
    logic       is_branch;
    logic [3:0] dec_idx;
    logic       stall;
    logic       pv;
    logic       pred;
    logic       alu_valid;
    logic       alu_out;
    logic [3:0] alu_idx;
    logic       drop;
    logic       init_done;
    logic [3:0] pht_addr;
    logic       pht_we;
    logic [1:0] pht_wdata;
    logic [1:0] pht_rdata;

    logic [1:0] mem [16];

    int checks = 0;
    int errors = 0;

    logic       sv_valid [1:40];
    logic [3:0] sv_idx   [1:40];
    logic       sv_out   [1:40];
    logic       st_a     [1:40];
    logic       we_a     [1:40];
    logic [3:0] addr_a   [1:40];
    logic [1:0] wd_a     [1:40];
    logic       pv_a     [1:40];
    logic       drop_a   [1:40];

    logic [3:0] wq_addr [$];
    logic [1:0] wq_data [$];

    bpred_pht_arbiter #(
        .BPRED_WIDTH  (4),
        .UPD_DEPTH    (4),
        .STARVE_LIMIT (8),
        .INIT_CTR     (2'b10)
    ) dut (
        .i_Clk                (clk),
        .i_Reset              (rst_n),
        .i_DEC_Is_Branch      (is_branch),
        .i_DEC_Index          (dec_idx),
        .o_Lookup_Stall       (stall),
        .o_Pred_Valid         (pv),
        .o_Prediction         (pred),
        .i_ALU_Branch_Valid   (alu_valid),
        .i_ALU_Branch_Outcome (alu_out),
        .i_ALU_Index          (alu_idx),
        .o_Upd_Drop           (drop),
        .o_Init_Done          (init_done),
        .o_PHT_Addr           (pht_addr),
        .o_PHT_We             (pht_we),
        .o_PHT_Wdata          (pht_wdata),
        .i_PHT_Rdata          (pht_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'b00;
        pht_rdata = 2'b00;
    end

    always @(posedge clk) begin
        if (pht_we) mem[pht_addr] <= pht_wdata;
        pht_rdata <= mem[pht_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int c = 1; c <= 40; c++) begin
            sv_valid[c] = 1'b0;
            sv_idx[c]   = 4'd0;
            sv_out[c]   = 1'b0;
        end
    endtask

    task automatic sched(input int c, input logic [3:0] idx, input logic outcome);
        sv_valid[c] = 1'b1;
        sv_idx[c]   = idx;
        sv_out[c]   = outcome;
    endtask

    task automatic run_cycles(input int first, input int last, input logic br);
        for (int c = first; c <= last; c++) begin
            is_branch = br;
            dec_idx   = 4'd0;
            alu_valid = sv_valid[c];
            alu_idx   = sv_idx[c];
            alu_out   = sv_out[c];
            #1;
            st_a[c]   = stall;
            we_a[c]   = pht_we;
            addr_a[c] = pht_addr;
            wd_a[c]   = pht_wdata;
            pv_a[c]   = pv;
            drop_a[c] = drop;
            @(negedge clk);
        end
        is_branch = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic collect_writes(input int first, input int last);
        wq_addr.delete();
        wq_data.delete();
        for (int c = first; c <= last; c++) begin
            if (we_a[c]) begin
                wq_addr.push_back(addr_a[c]);
                wq_data.push_back(wd_a[c]);
            end
        end
    endtask

    task automatic check_init_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            check({tag, "_addr"}, pht_addr, i);
            check({tag, "_we"}, pht_we, 1);
            check({tag, "_wdata"}, pht_wdata, 2'b10);
            check({tag, "_stall"}, stall, 1);
            @(negedge clk);
        end
    endtask

    task automatic lookup(input logic [3:0] idx, input logic exp_pred, input string tag);
        is_branch = 1'b1;
        dec_idx   = idx;
        #1;
        check({tag, "_stall"}, stall, 0);
        check({tag, "_addr"}, pht_addr, idx);
        check({tag, "_we"}, pht_we, 0);
        @(negedge clk);
        is_branch = 1'b0;
        #1;
        check({tag, "_pv"}, pv, 1);
        check({tag, "_pred"}, pred, exp_pred);
        @(negedge clk);
    endtask

    task automatic do_update(input logic [3:0] idx, input logic taken, input logic [1:0] exp_w,
                             input string tag);
        int  lat;
        logic found;
        lat   = 0;
        found = 1'b0;
        alu_valid = 1'b1;
        alu_idx   = idx;
        alu_out   = taken;
        #1;
        @(negedge clk);
        alu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (!found && pht_we) begin
                found = 1'b1;
                lat   = k;
                check({tag, "_addr"}, pht_addr, idx);
                check({tag, "_wdata"}, pht_wdata, exp_w);
            end
            @(negedge clk);
            if (found) break;
        end
        check({tag, "_latency"}, lat, 3);
    endtask

    initial begin
        int n;
        logic [3:0] exp_a [4];
        logic [1:0] exp_d [4];

        rst_n     = 1'b0;
        is_branch = 1'b0;
        dec_idx   = 4'd0;
        alu_valid = 1'b0;
        alu_out   = 1'b0;
        alu_idx   = 4'd0;
        clear_sched();

        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", stall, 1);
        check("rst_we", pht_we, 0);
        check("rst_pv", pv, 0);
        check("rst_pred", pred, 0);
        check("rst_drop", drop, 0);
        check("rst_init_done", init_done, 0);
        @(negedge clk);

        rst_n = 1'b1;
        check_init_sweep("init");
        #1;
        check("init_done", init_done, 1);
        check("init_stall_released", stall, 0);
        check("init_no_write", pht_we, 0);
        @(negedge clk);

        lookup(4'd5, 1'b1, "lk5_first");

        do_update(4'd5, 1'b0, 2'b01, "upd5_nt1");
        do_update(4'd5, 1'b0, 2'b00, "upd5_nt2");
        do_update(4'd5, 1'b0, 2'b00, "upd5_nt_sat");
        do_update(4'd3, 1'b1, 2'b11, "upd3_t1");
        do_update(4'd3, 1'b1, 2'b11, "upd3_t_sat");
        lookup(4'd5, 1'b0, "lk5_after");
        lookup(4'd3, 1'b1, "lk3_after");

        // Overflow and starvation under continuous lookups
        clear_sched();
        sched(1, 4'd7, 1'b1);
        sched(2, 4'd8, 1'b0);
        sched(3, 4'd9, 1'b1);
        sched(4, 4'd10, 1'b0);
        sched(5, 4'd11, 1'b1);
        run_cycles(1, 20, 1'b1);
        run_cycles(21, 40, 1'b0);
        check("drop_c5", drop_a[5], 0);
        check("drop_c6", drop_a[6], 1);
        check("drop_c7", drop_a[7], 0);
        n = 0;
        for (int c = 1; c <= 19; c++) if (st_a[c]) n++;
        check("starve_stall_count", n, 1);
        check("starve_stall_c11", st_a[11], 1);
        check("starve_rd_addr", addr_a[11], 7);
        check("starve_rd_we", we_a[11], 0);
        check("starve_lookup_c12", st_a[12], 0);
        check("starve_pv_c12", pv_a[12], 0);
        check("starve_pv_c13", pv_a[13], 1);
        check("starve_wr_stall", st_a[20], 1);
        check("starve_wr_we", we_a[20], 1);
        check("starve_wr_addr", addr_a[20], 7);
        check("starve_wr_data", wd_a[20], 2'b11);
        n = 0;
        for (int c = 1; c <= 19; c++) if (we_a[c]) n++;
        check("starve_no_early_write", n, 0);
        collect_writes(21, 40);
        check("drain1_count", wq_addr.size(), 3);
        exp_a[0] = 4'd8;  exp_d[0] = 2'b01;
        exp_a[1] = 4'd9;  exp_d[1] = 2'b11;
        exp_a[2] = 4'd10; exp_d[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            if (i < wq_addr.size()) begin
                check($sformatf("drain1_addr%0d", i), wq_addr[i], exp_a[i]);
                check($sformatf("drain1_data%0d", i), wq_data[i], exp_d[i]);
            end
        end

        // Reset while the update sits in WR
        alu_valid = 1'b1; alu_idx = 4'd12; alu_out = 1'b1;
        @(negedge clk);
        alu_idx = 4'd13; alu_out = 1'b0;
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        check("rstwr_rd_addr", pht_addr, 12);
        check("rstwr_rd_we", pht_we, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwr_we", pht_we, 0);
        check("rstwr_stall", stall, 1);
        check("rstwr_init_done", init_done, 0);
        @(negedge clk);
        #1;
        check("rstwr_mem12", mem[12], 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        check_init_sweep("reinit");
        clear_sched();
        run_cycles(1, 8, 1'b0);
        n = 0;
        for (int c = 1; c <= 8; c++) if (we_a[c]) n++;
        check("reinit_fifo_empty", n, 0);

        // Push and pop on the same cycle while full
        clear_sched();
        sched(1, 4'd1, 1'b0);
        sched(2, 4'd2, 1'b1);
        sched(3, 4'd4, 1'b0);
        sched(4, 4'd6, 1'b1);
        sched(20, 4'd14, 1'b0);
        run_cycles(1, 20, 1'b1);
        run_cycles(21, 40, 1'b0);
        n = 0;
        for (int c = 1; c <= 40; c++) if (drop_a[c]) n++;
        check("pp_no_drop", n, 0);
        check("pp_stall_c11", st_a[11], 1);
        check("pp_wr_we", we_a[20], 1);
        check("pp_wr_addr", addr_a[20], 1);
        check("pp_wr_data", wd_a[20], 2'b01);
        collect_writes(21, 40);
        check("pp_drain_count", wq_addr.size(), 4);
        exp_a[0] = 4'd2;  exp_d[0] = 2'b11;
        exp_a[1] = 4'd4;  exp_d[1] = 2'b01;
        exp_a[2] = 4'd6;  exp_d[2] = 2'b11;
        exp_a[3] = 4'd14; exp_d[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (i < wq_addr.size()) begin
                check($sformatf("pp_addr%0d", i), wq_addr[i], exp_a[i]);
                check($sformatf("pp_data%0d", i), wq_data[i], exp_d[i]);
            end
        end
        lookup(4'd14, 1'b0, "lk14");
        lookup(4'd2, 1'b1, "lk2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
